// File: rtl/multicycle_seq_ctrl.sv
// multicycle_seq_ctrl: FETCH/EXEC/MEM/WB sequencer with mem handshake, timeout, halt and counters
module multicycle_seq_ctrl #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_mem_to_reg,
  input  logic             dec_jump,
  input  logic [4:0]       dec_rd,
  input  logic [2:0]       dec_funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  next_pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [2:0]       mem_funct3,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             pc_write,
  output logic [XLEN-1:0]  pc_next,
  input  logic             halt_req,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH = 3'd0, EXEC = 3'd1, MEM = 3'd2, WB = 3'd3, HALT = 3'd4, ERR = 3'd5} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rw_q, rw_d, m2r_q, m2r_d, jmp_q, jmp_d;
  logic [4:0] rd_q, rd_d;
  logic [XLEN-1:0] alu_q, alu_d, pc4_q, pc4_d, npc_q, npc_d, rdata_q, rdata_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0] mem_f3_q, mem_f3_d;
  logic wb_we_q, wb_we_d, pc_write_q, pc_write_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d, pc_next_q, pc_next_d;
  logic halted_q, halted_d, mem_err_q, mem_err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rw_d        = rw_q;
    m2r_d       = m2r_q;
    jmp_d       = jmp_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    npc_d       = npc_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_f3_d    = mem_f3_q;
    wb_we_d     = 1'b0;
    pc_write_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    pc_next_d   = pc_next_q;
    halted_d    = halted_q;
    mem_err_d   = mem_err_q;
    ret_d       = ret_q;
    cyc_d       = cyc_q + CNT_W'(1);
    case (state_q)
      FETCH: begin
        if (halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (instr_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        rw_d  = dec_reg_write & ~dec_mem_write;
        m2r_d = dec_mem_to_reg;
        jmp_d = dec_jump;
        rd_d  = dec_rd;
        alu_d = alu_result;
        pc4_d = pc_plus4;
        npc_d = next_pc;
        if (dec_mem_read | dec_mem_write) begin
          state_d     = MEM;
          tmo_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dec_mem_write;
          mem_addr_d  = alu_result;
          mem_wdata_d = rs2_data;
          mem_f3_d    = dec_funct3;
        end else begin
          state_d    = WB;
          wb_we_d    = dec_reg_write && dec_rd != 5'd0;
          wb_rd_d    = dec_rd;
          wb_data_d  = dec_jump ? pc_plus4 : dec_mem_to_reg ? rdata_q : alu_result;
          pc_write_d = 1'b1;
          pc_next_d  = next_pc;
          ret_d      = ret_q + CNT_W'(1);
        end
      end
      MEM: begin
        tmo_d = tmo_q + TW'(1);
        if (mem_ack) begin
          state_d    = WB;
          tmo_d      = '0;
          rdata_d    = mem_rdata;
          mem_req_d  = 1'b0;
          wb_we_d    = rw_q && rd_q != 5'd0;
          wb_rd_d    = rd_q;
          wb_data_d  = jmp_q ? pc4_q : m2r_q ? mem_rdata : alu_q;
          pc_write_d = 1'b1;
          pc_next_d  = npc_q;
          ret_d      = ret_q + CNT_W'(1);
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          state_d   = ERR;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end
      end
      WB: state_d = FETCH;
      HALT: begin
        if (!halt_req) begin
          state_d  = FETCH;
          halted_d = 1'b0;
        end
      end
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      tmo_q       <= '0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      jmp_q       <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      npc_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_f3_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      pc_write_q  <= 1'b0;
      pc_next_q   <= '0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      cyc_q       <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rw_q        <= rw_d;
      m2r_q       <= m2r_d;
      jmp_q       <= jmp_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      npc_q       <= npc_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_f3_q    <= mem_f3_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      pc_write_q  <= pc_write_d;
      pc_next_q   <= pc_next_d;
      halted_q    <= halted_d;
      mem_err_q   <= mem_err_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
    end
  end
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_funct3   = mem_f3_q;
  assign wb_reg_write = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign pc_write     = pc_write_q;
  assign pc_next      = pc_next_q;
  assign halted       = halted_q;
  assign mem_err      = mem_err_q;
  assign cycle_cnt    = cyc_q;
  assign instret_cnt  = ret_q;
  assign state        = state_q;
endmodule

// File: doc/multicycle_seq_ctrl.md
Name: multicycle_seq_ctrl

Overview:
Parametrised N-phase execution sequencer for the single-issue RV32 core. Replaces the fixed two-phase execute/writeback toggle with a FETCH/EXEC/MEM/WB state machine. Adds a variable-latency data-memory req/ack handshake with timeout, halt/resume, and cycle and retired-instruction counters. It sits between the decoder/ALU datapath and the PC, register-file and data-memory ports.

Parameters:
XLEN, 32, datapath/address width
CNT_W, 32, width of cycle_cnt and instret_cnt
MEM_TIMEOUT, 255, max MEM-state cycles waiting for mem_ack before fault (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction memory output valid this cycle
dec_reg_write  in  1  decoder: instruction writes rd
dec_mem_read  in  1  decoder: load
dec_mem_write  in  1  decoder: store
dec_mem_to_reg  in  1  decoder: wb source is memory
dec_jump  in  1  decoder: JAL/JALR, wb source is pc_plus4
dec_rd  in  5  destination register
dec_funct3  in  3  memory access size/sign
alu_result  in  XLEN  ALU result / memory address
rs2_data  in  XLEN  store data
pc_plus4  in  XLEN  link value
next_pc  in  XLEN  resolved next PC (branch/jump/+4)
mem_req  out  1  data memory request, held until ack
mem_we  out  1  1=store, 0=load, valid with mem_req
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  store data
mem_funct3  out  3  access size
mem_ack  in  1  memory completes the request this cycle
mem_rdata  in  XLEN  load data, valid with mem_ack
wb_reg_write  out  1  register-file write enable, one-cycle pulse
wb_rd  out  5  write address
wb_data  out  XLEN  write data
pc_write  out  1  PC update pulse
pc_next  out  XLEN  value loaded into PC
halt_req  in  1  request stop at instruction boundary
halted  out  1  core stopped in HALT
mem_err  out  1  sticky memory-timeout fault
cycle_cnt  out  CNT_W  cycles since reset, wraps
instret_cnt  out  CNT_W  retired instructions, wraps
state  out  3  FETCH=0 EXEC=1 MEM=2 WB=3 HALT=4 ERR=5

Behaviour:
- Reset (async, rst_n=0): state=FETCH. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, wb_*, pc_write, pc_next, halted, mem_err, and both counters. The internal timeout counter is also 0. Reset mid-MEM drops mem_req immediately; no retire.
- All outputs are registered.
- FETCH:
  - halt_req=1 -> HALT; halt takes priority over instr_valid.
  - else instr_valid=1 -> EXEC.
  - else stay.
- EXEC: latch dec_*, alu_result, rs2_data, pc_plus4, next_pc.
  - If dec_mem_read or dec_mem_write: next cycle mem_req=1, mem_we=dec_mem_write, mem_addr=alu_result, mem_wdata=rs2_data, mem_funct3=dec_funct3; go to MEM.
  - Else -> WB.
  - If read and write are both asserted, the store wins.
- MEM: address/data held stable while mem_req=1. The timeout counter increments each cycle.
  - mem_ack=1: latch mem_rdata, clear mem_req next cycle, -> WB. Ack in the first MEM cycle is legal.
  - Timeout counter reaches MEM_TIMEOUT without ack: -> ERR, clear mem_req, mem_err=1.
  - mem_ack outside MEM is ignored.
- WB: one-cycle pulse of pc_write=1 with pc_next=saved next_pc.
  - wb_reg_write=saved reg_write && rd!=0.
  - wb_data priority: jump -> pc_plus4; mem_to_reg -> latched rdata; else alu_result.
  - wb_rd=saved rd.
  - instret_cnt+1, then -> FETCH.
  - Stores never assert wb_reg_write.
- HALT: halted=1; leave to FETCH when halt_req=0 (halted clears that cycle). halt_req during EXEC/MEM/WB is honoured only at the next FETCH; the in-flight instruction always retires.
- ERR: terminal until reset. No pc_write, wb_reg_write or mem_req. cycle_cnt keeps counting.
- cycle_cnt increments every cycle out of reset. Both counters wrap 2^CNT_W-1 -> 0.
- Latency with instr_valid steady: ALU/jump = 3 cycles/instr; load/store = 4 + (ack wait cycles).

Test Plan:
- ADD, rd=5, alu_result=0x0000_0010, next_pc=0x104, instr_valid=1 -> states FETCH,EXEC,WB; WB-cycle wb_reg_write=1, wb_rd=5, wb_data=0x10, pc_write=1, pc_next=0x104; instret_cnt=1.
- Load rd=7, addr 0x20, mem_ack after 3 wait cycles with rdata 0xDEADBEEF -> mem_req high 4 cycles, mem_we=0, mem_addr=0x20; wb_data=0xDEADBEEF; total 7 cycles.
- Store addr 0x40, rs2_data 0x55, immediate ack -> mem_we=1, mem_wdata=0x55, wb_reg_write=0, pc_write=1.
- JAL, rd=1, pc_plus4=0x8, next_pc=0x100 -> wb_data=0x8, pc_next=0x100; ADD with rd=0 -> wb_reg_write=0, pc_write=1.
- MEM_TIMEOUT=4, load never acked -> after 4 MEM cycles state=ERR, mem_err=1, mem_req=0, no further pc_write.
- halt_req raised during load MEM -> load retires; FETCH->HALT, halted=1; drop halt_req -> FETCH, halted=0. rst_n low mid-MEM -> all outputs 0 asynchronously.
